// File: rtl/ccsds123_in_sched.sv
// rtl/ccsds123_in_sched.sv - packs a serial sample stream into PIPELINES-lane beats per image
// One accumulator plus one output register; a completed beat waits in the accumulator if the output is busy.
module ccsds123_in_sched #(
    parameter int PIPELINES = 4,
    parameter int D         = 16,
    parameter int NX        = 32,
    parameter int NY        = 32,
    parameter int NZ        = 16
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [D-1:0]           s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [PIPELINES*D-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [PIPELINES-1:0]   m_tkeep,
    output logic                   m_tlast,
    output logic                   image_done,
    output logic [15:0]            image_count
);

    localparam int N  = NX * NY * NZ;
    localparam int CW = $clog2(N + 1);
    localparam int LW = (PIPELINES > 1) ? $clog2(PIPELINES) : 1;

    logic [PIPELINES-1:0][D-1:0] r_acc;
    logic [LW-1:0]               r_lane_idx;
    logic [CW-1:0]               r_sample_cnt;
    logic                        r_acc_full;
    logic                        r_acc_last;
    logic [PIPELINES*D-1:0]      r_m_tdata;
    logic                        r_m_tvalid;
    logic [PIPELINES-1:0]        r_m_tkeep;
    logic                        r_m_tlast;
    logic                        r_image_done;
    logic [15:0]                 r_image_count;

    logic                        w_in_hs;
    logic                        w_out_hs;
    logic                        w_out_free;
    logic                        w_last_smp;
    logic                        w_complete;
    logic                        w_load;
    logic                        w_beat_last;
    logic [PIPELINES-1:0][D-1:0] w_beat;
    logic [PIPELINES-1:0]        w_keep;

    assign s_tready    = !r_acc_full;
    assign w_in_hs     = s_tvalid && !r_acc_full;
    assign w_out_hs    = r_m_tvalid && m_tready;
    assign w_out_free  = !r_m_tvalid || m_tready;
    assign w_last_smp  = (r_sample_cnt == CW'(N - 1));
    assign w_complete  = w_in_hs && ((r_lane_idx == LW'(PIPELINES - 1)) || w_last_smp);
    assign w_load      = w_out_free && (w_complete || r_acc_full);
    assign w_beat_last = w_in_hs ? w_last_smp : r_acc_last;

    // Unfilled lanes are already zero because the accumulator is cleared on every transfer.
    always_comb begin
        w_beat = r_acc;
        w_keep = '0;
        for (int k = 0; k < PIPELINES; k++) begin
            if (w_in_hs && (LW'(k) == r_lane_idx)) begin
                w_beat[k] = s_tdata;
            end
            w_keep[k] = (LW'(k) <= r_lane_idx);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc         <= '0;
            r_lane_idx    <= '0;
            r_sample_cnt  <= '0;
            r_acc_full    <= 1'b0;
            r_acc_last    <= 1'b0;
            r_m_tdata     <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tkeep     <= '0;
            r_m_tlast     <= 1'b0;
            r_image_done  <= 1'b0;
            r_image_count <= '0;
        end else begin
            if (w_in_hs) begin
                r_sample_cnt <= w_last_smp ? '0 : r_sample_cnt + CW'(1);
            end

            if (w_load) begin
                r_m_tdata  <= w_beat;
                r_m_tkeep  <= w_keep;
                r_m_tlast  <= w_beat_last;
                r_m_tvalid <= 1'b1;
                r_acc      <= '0;
                r_lane_idx <= '0;
                r_acc_full <= 1'b0;
                r_acc_last <= 1'b0;
            end else begin
                if (w_out_hs) begin
                    r_m_tvalid <= 1'b0;
                end
                if (w_in_hs) begin
                    r_acc[r_lane_idx] <= s_tdata;
                    // A completed beat that cannot move keeps lane_idx so its keep mask survives.
                    if (w_complete) begin
                        r_acc_full <= 1'b1;
                        r_acc_last <= w_last_smp;
                    end else begin
                        r_lane_idx <= r_lane_idx + LW'(1);
                    end
                end
            end

            r_image_done <= w_out_hs && r_m_tlast;
            if (w_out_hs && r_m_tlast) begin
                r_image_count <= r_image_count + 16'd1;
            end
        end
    end

    assign m_tdata     = r_m_tdata;
    assign m_tvalid    = r_m_tvalid;
    assign m_tkeep     = r_m_tkeep;
    assign m_tlast     = r_m_tlast;
    assign image_done  = r_image_done;
    assign image_count = r_image_count;

endmodule

// File: tb/tb_ccsds123_in_sched.sv
// tb/tb_ccsds123_in_sched.sv - scoreboard bench for ccsds123_in_sched with N=16 and N=9 instances
module tb_ccsds123_in_sched;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic [1:0][15:0]  s_tdata;
    logic [1:0]        s_tvalid;
    logic [1:0]        s_tready;
    logic [1:0][63:0]  m_tdata;
    logic [1:0]        m_tvalid;
    logic [1:0]        m_tready;
    logic [1:0][3:0]   m_tkeep;
    logic [1:0]        m_tlast;
    logic [1:0]        image_done;
    logic [1:0][15:0]  image_count;

    always #5 clk = ~clk;

    ccsds123_in_sched #(.PIPELINES(4), .D(16), .NX(2), .NY(2), .NZ(4)) u_dut16 (
        .clk(clk), .aresetn(aresetn),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
        .m_tkeep(m_tkeep[0]), .m_tlast(m_tlast[0]),
        .image_done(image_done[0]), .image_count(image_count[0])
    );

    ccsds123_in_sched #(.PIPELINES(4), .D(16), .NX(3), .NY(1), .NZ(3)) u_dut9 (
        .clk(clk), .aresetn(aresetn),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
        .m_tkeep(m_tkeep[1]), .m_tlast(m_tlast[1]),
        .image_done(image_done[1]), .image_count(image_count[1])
    );

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    beat_t       mon_e;

    logic [1:0]  stall_prev;
    logic [1:0]  done_exp;
    logic [63:0] prev_data[2];
    logic [4:0]  prev_kl[2];
    int          beats_seen[2];
    int          stall_cnt[2];
    int          done_pulses[2];
    logic [15:0] cap_b3;

    logic        model_en;
    logic [15:0] mdl_acc[4];
    int          mdl_lane;
    int          mdl_cnt;
    logic        tx_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [63:0] data, input logic [3:0] keep, input logic last);
        beat_t b;
        b.data = data;
        b.keep = keep;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) mdl_acc[k] = '0;
        mdl_lane = 0;
        mdl_cnt  = 0;
    endtask

    // Reference packing: lanes fill in order, beat closes at lane 3 or at the image's last sample.
    task automatic model_sample(input int d, input logic [15:0] v);
        int n;
        logic last;
        n = (d == 0) ? 16 : 9;
        mdl_acc[mdl_lane] = v;
        last = (mdl_cnt == n - 1);
        if (mdl_lane == 3 || last) begin
            push_beat({mdl_acc[3], mdl_acc[2], mdl_acc[1], mdl_acc[0]},
                      4'((1 << (mdl_lane + 1)) - 1), last);
            for (int k = 0; k < 4; k++) mdl_acc[k] = '0;
            mdl_lane = 0;
        end else begin
            mdl_lane++;
        end
        mdl_cnt = last ? 0 : mdl_cnt + 1;
    endtask

    task automatic send(input int d, input logic [15:0] v, input int gap);
        logic hs;
        hs = 1'b0;
        for (int g = 0; g < gap; g++) begin
            s_tvalid[d] = 1'b0;
            s_tdata[d]  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        s_tvalid[d] = 1'b1;
        s_tdata[d]  = v;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            hs = s_tready[d];
            @(posedge clk);
            #1;
            if (hs) break;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d actual=no_handshake expected=handshake", d);
        end else if (model_en) begin
            model_sample(d, v);
        end
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 2'b00;
        m_tready = 2'b11;
        exp_q.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_m_tvalid", m_tvalid[d], 0);
            check("rst_m_tlast", m_tlast[d], 0);
            check("rst_m_tkeep", m_tkeep[d], 0);
            check("rst_m_tdata", m_tdata[d], 0);
            check("rst_image_done", image_done[d], 0);
            check("rst_image_count", image_count[d], 0);
        end
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_s_tready0", s_tready[0], 1);
        check("rst_s_tready1", s_tready[1], 1);
    endtask

    task automatic drain(input string name, input int d, input int exp_count);
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_image_count"}, image_count[d], exp_count);
        check({name, "_done_pulses"}, done_pulses[d], exp_count);
    endtask

    task automatic push_case1_beats();
        for (int b = 0; b < 4; b++) begin
            push_beat({16'(4*b+3), 16'(4*b+2), 16'(4*b+1), 16'(4*b)}, 4'b1111, b == 3);
        end
    endtask

    always @(negedge clk) begin
        if (!aresetn) begin
            stall_prev = 2'b00;
            done_exp   = 2'b00;
            for (int d = 0; d < 2; d++) begin
                beats_seen[d]  = 0;
                stall_cnt[d]   = 0;
                done_pulses[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (stall_prev[d]) begin
                    check("hold_valid", m_tvalid[d], 1);
                    check("hold_data", m_tdata[d], prev_data[d]);
                    check("hold_keep_last", {m_tkeep[d], m_tlast[d]}, prev_kl[d]);
                end
                check("image_done", image_done[d], done_exp[d]);
                if (image_done[d]) done_pulses[d]++;
                done_exp[d] = m_tvalid[d] && m_tready[d] && m_tlast[d];
                if (m_tvalid[d] && m_tready[d]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat dut%0d actual=%0h expected=none", d, m_tdata[d]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat_data", m_tdata[d], mon_e.data);
                        check("beat_keep", m_tkeep[d], mon_e.keep);
                        check("beat_last", m_tlast[d], mon_e.last);
                    end
                    if (d == 1 && beats_seen[1] == 3) cap_b3 = m_tdata[1][15:0];
                    beats_seen[d]++;
                end
                if (!s_tready[d]) stall_cnt[d]++;
                stall_prev[d] = m_tvalid[d] && !m_tready[d];
                prev_data[d]  = m_tdata[d];
                prev_kl[d]    = {m_tkeep[d], m_tlast[d]};
            end
        end
    end

    initial begin
        s_tdata  = '0;
        s_tvalid = 2'b00;
        m_tready = 2'b11;
        model_en = 1'b0;
        tx_done  = 1'b0;
        cap_b3   = '0;
        model_clear();

        // Case 1: N=16 ramp at full rate
        do_reset();
        model_en = 1'b0;
        push_case1_beats();
        for (int i = 0; i < 16; i++) send(0, 16'(i), 0);
        s_tvalid[0] = 1'b0;
        drain("c1", 0, 1);
        check("c1_beats", beats_seen[0], 4);

        // Case 2: N=9, final beat has only lane 0
        do_reset();
        push_beat({16'd4, 16'd3, 16'd2, 16'd1}, 4'b1111, 1'b0);
        push_beat({16'd8, 16'd7, 16'd6, 16'd5}, 4'b1111, 1'b0);
        push_beat({16'd0, 16'd0, 16'd0, 16'd9}, 4'b0001, 1'b1);
        for (int i = 0; i < 9; i++) send(1, 16'(i + 1), 0);
        s_tvalid[1] = 1'b0;
        drain("c2", 1, 1);

        // Case 3: downstream stall after the first beat
        do_reset();
        model_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) send(0, 16'(i), 0);
                s_tvalid[0] = 1'b0;
            end
            begin
                for (int t = 0; t < 300; t++) begin
                    if (beats_seen[0] >= 1) break;
                    @(posedge clk);
                    #1;
                end
                m_tready[0] = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                m_tready[0] = 1'b1;
            end
        join
        drain("c3", 0, 1);
        check("c3_s_tready_dropped", stall_cnt[0] > 0, 1);
        check("c3_beats", beats_seen[0], 4);

        // Case 4: two back-to-back N=9 images
        do_reset();
        for (int i = 0; i < 9; i++) send(1, 16'(i + 1), 0);
        for (int i = 0; i < 9; i++) send(1, 16'(i + 101), 0);
        s_tvalid[1] = 1'b0;
        drain("c4", 1, 2);
        check("c4_img2_lane0", cap_b3, 16'd101);
        check("c4_beats", beats_seen[1], 6);

        // Case 5: reset mid-image, then a clean image must match case 1
        do_reset();
        for (int i = 0; i < 6; i++) send(0, 16'(i + 500), 0);
        s_tvalid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        model_en = 1'b0;
        push_case1_beats();
        for (int i = 0; i < 16; i++) send(0, 16'(i), 0);
        s_tvalid[0] = 1'b0;
        drain("c5", 0, 1);

        // Case 6: sparse input and random backpressure over three images
        do_reset();
        model_en = 1'b1;
        tx_done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 48; i++) send(0, 16'($urandom), $urandom_range(0, 4));
                s_tvalid[0] = 1'b0;
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    @(posedge clk);
                    #1;
                    m_tready[0] = 1'($urandom_range(0, 1));
                end
            end
        join
        m_tready[0] = 1'b1;
        drain("c6", 0, 3);
        check("c6_beats", beats_seen[0], 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
